adc_sdo_emulator: RTL and testbench
===================================

ADC_SDO_EMULATOR -- requirements
Module: adc_sdo_emulator

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width per ADC channel, even values only.
REQ-002 SHALL have parameter CONV_CYCLES, default 20: clk cycles from detected CNV_n fall to data ready.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on CNV_n and SCK inputs.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_ADC_CNV_n  input  4  per-channel convert start, negative polarity.
REQ-007 SHALL have port i_ADC_SCK  input  4  per-channel SPI serial clock from the acquisition master.
REQ-008 SHALL have port o_ADC_SDO  output  8  serial data; lanes 2k and 2k+1 belong to channel k.
REQ-009 SHALL have port o_busy  output  4  per-channel conversion in progress.
REQ-010 SHALL have port o_overrun  output  4  per-channel sticky flag: new CNV_n fall before all bits shifted out.

Function
REQ-011 SHALL synchronize each CNV_n and SCK bit through SYNC_STAGES flops, then edge-detect against one extra registered copy; an input edge SHALL be acted on at the (SYNC_STAGES+1)th clk edge after it.
REQ-012 SHALL run one independent per-channel FSM with states IDLE, CONVERT, SHIFT.
REQ-013 IDLE -> CONVERT on detected CNV_n fall; o_busy[k] SHALL go high in that same cycle.
REQ-014 CONVERT SHALL last exactly CONV_CYCLES cycles; SCK edges in CONVERT SHALL be ignored.
REQ-015 CONVERT -> SHIFT: the sample is loaded, o_busy[k] drops, and the first bits SHALL appear on SDO in the first SHIFT cycle.
REQ-016 Lane 2k SHALL carry sample[DATA_W-1:DATA_W/2], lane 2k+1 SHALL carry sample[DATA_W/2-1:0], both MSB first.
REQ-017 Each detected SCK falling edge in SHIFT SHALL advance both lanes by one bit; the receiver samples on SCK rising edges.
REQ-018 After DATA_W/2 bits, further SCK falls SHALL drive 0 on both lanes; FSM SHALL return to IDLE after the (DATA_W/2)th fall.
REQ-019 SDO SHALL be 0 in IDLE and CONVERT.
REQ-020 Sample value (default) SHALL be {k[1:0], cnt_k[DATA_W-3:0]}; cnt_k resets to 0 and increments by 1 modulo 2^(DATA_W-2) at each conversion start, after its value is captured.
REQ-021 CNV_n fall in SHIFT SHALL abort the shift, set o_overrun[k], and enter CONVERT in the same cycle.
REQ-022 CNV_n fall in CONVERT SHALL restart the CONVERT count from zero and set o_overrun[k].
REQ-023 Simultaneous CNV_n fall and SCK fall in one cycle: CNV_n SHALL take priority.
REQ-024 o_overrun[k] SHALL clear only on reset.

Reset
REQ-025 On rst_n low, all FSMs SHALL enter IDLE; o_ADC_SDO, o_busy, o_overrun, cnt_k, and synchronizer flops SHALL all be 0, except CNV_n synchronizers, which reset to 1.
REQ-026 Reset asserted mid-CONVERT or mid-SHIFT SHALL discard the sample with no output glitch beyond a transition to 0.
REQ-027 Deassertion SHALL be synchronized to clk internally, so the FSMs leave reset in a single cycle.

Configuration
REQ-028 With ADC_EMU_PRBS_EN defined, the sample SHALL be taken from a per-channel DATA_W-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1 for 16 bits) seeded with {k+1} at reset and stepped once per conversion start.
REQ-029 Without ADC_EMU_PRBS_EN, the counter pattern of REQ-020 SHALL be used and no LFSR logic SHALL be present.

Structure
REQ-030 Package adc_emu_pkg SHALL hold the FSM state enum, N_CH=4, LANES_PER_CH=2, and the LFSR tap constant.
REQ-031 The per-channel FSM, shifter, and pattern source SHALL be sub-module adc_emu_channel, instantiated N_CH times by the top.

Verification
REQ-032 Reset, then one CNV_n pulse on channel 0 and 8 SCK cycles -> receiver reassembles 0x0000, o_busy[0] high for exactly 20 cycles.
REQ-033 Three successive conversions on channel 2 -> words 0x8000, 0x8001, 0x8002; o_overrun = 0.
REQ-034 CNV_n fall on channel 1 after 3 SCK cycles -> o_overrun[1] = 1, next full read returns 0x4001, other channels unaffected.
REQ-035 12 SCK cycles after one conversion -> bits 9..12 read 0 on both lanes, FSM in IDLE.
REQ-036 All four channels converted simultaneously -> lanes return 0x0000, 0x4000, 0x8000, 0xC000 concurrently.
REQ-037 With ADC_EMU_PRBS_EN, channel 0 first word = LFSR state after one step from seed 0x0001, cross-checked against a bench model over 1000 conversions.

Source files
------------

// File: rtl/adc_emu_pkg.sv
// +----------------------------------------------------------------------------+
// | adc_emu_pkg                                                                |
// | Shared types and constants for the ADC SDO emulator.                       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package adc_emu_pkg;

  localparam int N_CH         = 4;
  localparam int LANES_PER_CH = 2;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15, 13, 12, 10)
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_SHIFT   = 2'd2
  } ch_state_t;

endpackage

`default_nettype wire

// File: rtl/adc_emu_channel.sv
// +----------------------------------------------------------------------------+
// | adc_emu_channel                                                            |
// | One emulated ADC channel: input sync, conversion FSM, dual-lane shifter    |
// | and sample source (counter, or LFSR when ADC_EMU_PRBS_EN is defined).      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module adc_emu_channel
  import adc_emu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 20,
  parameter int SYNC_STAGES = 2,
  parameter int CH_IDX      = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cnv_n,
  input  logic                    i_sck,
  output logic [LANES_PER_CH-1:0] o_sdo,
  output logic                    o_busy,
  output logic                    o_overrun
);

  localparam int             c_HALF      = DATA_W / 2;
  localparam int             c_PAT_W     = DATA_W - 2;
  localparam int             c_CNT_W     = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int             c_BIT_W     = (c_HALF > 1) ? $clog2(c_HALF) : 1;
  localparam logic [c_CNT_W-1:0] c_CONV_LAST = c_CNT_W'(CONV_CYCLES - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST  = c_BIT_W'(c_HALF - 1);
  localparam logic [1:0]     c_CH_ID     = 2'(CH_IDX);

  logic [SYNC_STAGES-1:0] r_cnv_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic                   r_cnv_prev;
  logic                   r_sck_prev;
  logic                   w_cnv_fall;
  logic                   w_sck_fall;

  ch_state_t              r_state;
  ch_state_t              w_state_nxt;
  logic                   w_start;
  logic                   w_load;
  logic                   w_shift;
  logic                   w_overrun_set;

  logic [c_CNT_W-1:0]     r_conv_cnt;
  logic [c_BIT_W-1:0]     r_bit_cnt;
  logic [c_HALF-1:0]      r_sh_hi;
  logic [c_HALF-1:0]      r_sh_lo;
  logic [DATA_W-1:0]      r_sample;
  logic [DATA_W-1:0]      w_pattern;
  logic                   r_overrun;

  // CNV_n idles high, so its chain resets to 1 to avoid a false fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnv_sync <= '1;
      r_cnv_prev <= 1'b1;
      r_sck_sync <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_cnv_sync <= SYNC_STAGES'({r_cnv_sync, i_cnv_n});
      r_cnv_prev <= r_cnv_sync[SYNC_STAGES-1];
      r_sck_sync <= SYNC_STAGES'({r_sck_sync, i_sck});
      r_sck_prev <= r_sck_sync[SYNC_STAGES-1];
    end
  end

  assign w_cnv_fall = r_cnv_prev & ~r_cnv_sync[SYNC_STAGES-1];
  assign w_sck_fall = r_sck_prev & ~r_sck_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every accepted CNV_n fall begins a new conversion and wins over SCK
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    w_overrun_set = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cnv_fall) begin
          w_state_nxt = ST_CONVERT;
          w_start     = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (w_cnv_fall) begin
          w_start       = 1'b1;
          w_overrun_set = 1'b1;
        end else if (r_conv_cnt == c_CONV_LAST) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_cnv_fall) begin
          w_state_nxt   = ST_CONVERT;
          w_start       = 1'b1;
          w_overrun_set = 1'b1;
        end else if (w_sck_fall) begin
          w_shift = 1'b1;
          if (r_bit_cnt == c_BIT_LAST) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_cnt <= '0;
    end else if (w_start) begin
      r_conv_cnt <= '0;
    end else if (r_state == ST_CONVERT) begin
      r_conv_cnt <= r_conv_cnt + c_CNT_W'(1);
    end
  end

  // Shift registers are zero whenever the channel is not shifting, so SDO
  // needs no extra gating and drops cleanly on abort or completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_hi   <= '0;
      r_sh_lo   <= '0;
      r_bit_cnt <= '0;
    end else if (w_load) begin
      r_sh_hi   <= r_sample[DATA_W-1:c_HALF];
      r_sh_lo   <= r_sample[c_HALF-1:0];
      r_bit_cnt <= '0;
    end else if (w_state_nxt != ST_SHIFT) begin
      r_sh_hi   <= '0;
      r_sh_lo   <= '0;
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_sh_hi   <= {r_sh_hi[c_HALF-2:0], 1'b0};
      r_sh_lo   <= {r_sh_lo[c_HALF-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
    end
  end

`ifdef ADC_EMU_PRBS_EN
  localparam logic [DATA_W-1:0] c_TAPS = DATA_W'(c_LFSR_TAPS);

  logic [DATA_W-1:0] r_lfsr;
  logic [DATA_W-1:0] w_lfsr_nxt;

  assign w_lfsr_nxt = {r_lfsr[DATA_W-2:0], ^(r_lfsr & c_TAPS)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= DATA_W'(CH_IDX + 1);
    end else if (w_start) begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  assign w_pattern = w_lfsr_nxt;
`else
  logic [c_PAT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= r_cnt + c_PAT_W'(1);
    end
  end

  assign w_pattern = {c_CH_ID, r_cnt};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_start) begin
        r_sample <= w_pattern;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_sdo     = {r_sh_lo[c_HALF-1], r_sh_hi[c_HALF-1]};
  assign o_busy    = (r_state == ST_CONVERT);
  assign o_overrun = r_overrun;

endmodule

`default_nettype wire

// File: rtl/adc_sdo_emulator.sv
// +----------------------------------------------------------------------------+
// | adc_sdo_emulator                                                           |
// | Four-channel dual-lane SPI ADC emulator. Define ADC_EMU_PRBS_EN to source  |
// | samples from per-channel LFSRs instead of the counter pattern.             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module adc_sdo_emulator
  import adc_emu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int CONV_CYCLES = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CH-1:0]                i_ADC_CNV_n,
  input  logic [N_CH-1:0]                i_ADC_SCK,
  output logic [N_CH*LANES_PER_CH-1:0]   o_ADC_SDO,
  output logic [N_CH-1:0]                o_busy,
  output logic [N_CH-1:0]                o_overrun
);

  logic r_rst_meta;
  logic r_rst_sync;

  // Assert immediately, release on a clock edge so all channels exit together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      adc_emu_channel #(
        .DATA_W      (DATA_W),
        .CONV_CYCLES (CONV_CYCLES),
        .SYNC_STAGES (SYNC_STAGES),
        .CH_IDX      (gi)
      ) u_ch (
        .clk       (clk),
        .rst_n     (r_rst_sync),
        .i_cnv_n   (i_ADC_CNV_n[gi]),
        .i_sck     (i_ADC_SCK[gi]),
        .o_sdo     (o_ADC_SDO[gi*LANES_PER_CH +: LANES_PER_CH]),
        .o_busy    (o_busy[gi]),
        .o_overrun (o_overrun[gi])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_adc_sdo_emulator.sv
// +----------------------------------------------------------------------------+
// | tb_adc_sdo_emulator                                                        |
// | Self-checking bench for adc_sdo_emulator (honours ADC_EMU_PRBS_EN).        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_adc_sdo_emulator;

  localparam int DATA_W      = 16;
  localparam int CONV_CYCLES = 20;
  localparam int SYNC_STAGES = 2;
`ifdef ADC_EMU_PRBS_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 60;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] cnv_n = 4'hF;
  logic [3:0] sck = 4'h0;
  logic [7:0] sdo;
  logic [3:0] busy;
  logic [3:0] ovr;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned conv_n   [4];
  logic [15:0] lfsr_m   [4];
  logic [15:0] exp_word [4];
  logic [31:0] acc_hi   [4];
  logic [31:0] acc_lo   [4];

  always #5 clk = ~clk;

  adc_sdo_emulator #(
    .DATA_W      (DATA_W),
    .CONV_CYCLES (CONV_CYCLES),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ADC_CNV_n (cnv_n),
    .i_ADC_SCK   (sck),
    .o_ADC_SDO   (sdo),
    .o_busy      (busy),
    .o_overrun   (ovr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // x^16+x^14+x^13+x^11+1: feedback from stages 16, 14, 13, 11
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      conv_n[c] = 0;
      lfsr_m[c] = 16'(c + 1);
    end
  endtask

  task automatic model_start(input int c);
`ifdef ADC_EMU_PRBS_EN
    lfsr_m[c]   = lfsr_step(lfsr_m[c]);
    exp_word[c] = lfsr_m[c];
`else
    exp_word[c] = 16'(c * 16384 + (conv_n[c] % 16384));
`endif
    conv_n[c]++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_sdo", 32'(sdo), 0);
    check("rst_busy", 32'(busy), 0);
    tick(3);
    check("rst_ovr", 32'(ovr), 0);
    cnv_n = 4'hF;
    sck   = 4'h0;
    model_reset();
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic start_cnv(input logic [3:0] mask, input int hold);
    for (int c = 0; c < 4; c++) if (mask[c]) model_start(c);
    cnv_n = cnv_n & ~mask;
    tick(hold);
    cnv_n = cnv_n | mask;
  endtask

  // Receiver samples each lane just as it raises SCK
  task automatic read_bits(input logic [3:0] mask, input int nbits, input int low, input int high);
    for (int c = 0; c < 4; c++) if (mask[c]) begin
      acc_hi[c] = '0;
      acc_lo[c] = '0;
    end
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < 4; c++) if (mask[c]) begin
        acc_hi[c] = {acc_hi[c][30:0], sdo[2*c]};
        acc_lo[c] = {acc_lo[c][30:0], sdo[2*c+1]};
      end
      sck = sck | mask;
      tick(high);
      sck = sck & ~mask;
      tick(low);
    end
  endtask

  function automatic logic [15:0] word_of(input int c, input int nbits);
    logic [31:0] h;
    logic [31:0] l;
    h = acc_hi[c] >> (nbits - 8);
    l = acc_lo[c] >> (nbits - 8);
    return {h[7:0], l[7:0]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          w;
    int          len;
    logic [3:0]  mask;
    int          hold;
    int          nb;
    int          lo_t;
    int          hi_t;

    do_reset();

    // single conversion on channel 0, busy width and quiet SDO while converting
    start_cnv(4'b0001, 2);
    w = 0;
    while (!busy[0] && w < 10) begin tick(1); w++; end
    check("busy0_rise", 32'(busy[0]), 1);
    len = 0;
    while (busy[0] && len < 40) begin
      if (len == 10) check("sdo0_in_convert", 32'(sdo[1:0]), 0);
      tick(1);
      len++;
    end
    check("busy0_len", len, CONV_CYCLES);
    read_bits(4'b0001, 8, 4, 3);
    check("ch0_word", 32'(word_of(0, 8)), 32'(exp_word[0]));
`ifdef ADC_EMU_PRBS_EN
    check("ch0_prbs_first", 32'(word_of(0, 8)), 32'h0002);
`endif
    check("ch0_idle_sdo", 32'(sdo), 0);

    // three back-to-back conversions on channel 2
    for (int k = 0; k < 3; k++) begin
      start_cnv(4'b0100, 2);
      tick(22);
      check("ch2_done", 32'(busy), 0);
      read_bits(4'b0100, 8, 3, 2);
      check("ch2_word", 32'(word_of(2, 8)), 32'(exp_word[2]));
    end
    check("ch2_no_ovr", 32'(ovr), 0);

    // abort a partial read on channel 1
    start_cnv(4'b0010, 2);
    tick(22);
    read_bits(4'b0010, 3, 3, 2);
    start_cnv(4'b0010, 2);
    tick(2);
    check("ch1_ovr", 32'(ovr), 32'h2);
    check("ch1_busy_again", 32'(busy), 32'h2);
    check("ch1_sdo_zero", 32'(sdo[3:2]), 0);
    tick(20);
    read_bits(4'b0010, 8, 3, 2);
    check("ch1_word_after_abort", 32'(word_of(1, 8)), 32'(exp_word[1]));
    check("ch1_ovr_isolated", 32'(ovr), 32'h2);

    // over-read on channel 3: trailing bits are zero, channel back in IDLE
    start_cnv(4'b1000, 1);
    tick(23);
    read_bits(4'b1000, 12, 3, 2);
    check("ch3_word", 32'(word_of(3, 12)), 32'(exp_word[3]));
    check("ch3_tail_hi", 32'(acc_hi[3][3:0]), 0);
    check("ch3_tail_lo", 32'(acc_lo[3][3:0]), 0);
    check("ch3_idle_busy", 32'(busy[3]), 0);
    check("ch3_idle_sdo", 32'(sdo[7:6]), 0);

    // reset in the middle of a shift
    start_cnv(4'b0001, 2);
    tick(22);
    read_bits(4'b0001, 3, 3, 2);
    sck = 4'b0001;
    do_reset();

    // all four channels together
    start_cnv(4'b1111, 2);
    tick(22);
    check("all_done", 32'(busy), 0);
    read_bits(4'b1111, 8, 3, 2);
    for (int c = 0; c < 4; c++) check("all_word", 32'(word_of(c, 8)), 32'(exp_word[c]));

    // CNV_n fall during CONVERT restarts the conversion
    start_cnv(4'b0001, 2);
    tick(8);
    start_cnv(4'b0001, 2);
    tick(18);
    check("restart_busy_held", 32'(busy[0]), 1);
    check("restart_ovr", 32'(ovr[0]), 1);
    tick(6);
    check("restart_busy_end", 32'(busy[0]), 0);
    do_reset();

    // CNV_n and SCK falling in the same cycle: conversion wins
    start_cnv(4'b0100, 2);
    tick(22);
    read_bits(4'b0100, 2, 3, 2);
    sck[2] = 1'b1;
    tick(3);
    model_start(2);
    sck[2]   = 1'b0;
    cnv_n[2] = 1'b0;
    tick(2);
    cnv_n[2] = 1'b1;
    tick(2);
    check("simul_busy", 32'(busy[2]), 1);
    check("simul_ovr", 32'(ovr), 32'h4);
    tick(20);
    read_bits(4'b0100, 8, 3, 2);
    check("simul_word", 32'(word_of(2, 8)), 32'(exp_word[2]));
    do_reset();

    // randomized conversions against the model
    for (int it = 0; it < N_RAND; it++) begin
      mask = 4'($urandom_range(1, 15));
`ifdef ADC_EMU_PRBS_EN
      mask = mask | 4'b0001;
      nb   = 8;
`else
      nb   = int'($urandom_range(8, 10));
`endif
      hold = int'($urandom_range(1, 3));
      lo_t = int'($urandom_range(3, 4));
      hi_t = int'($urandom_range(2, 3));
      start_cnv(mask, hold);
      tick(24 - hold);
      read_bits(mask, nb, lo_t, hi_t);
      for (int c = 0; c < 4; c++) if (mask[c])
        check("rand_word", 32'(word_of(c, nb)), 32'(exp_word[c]));
    end
    check("rand_no_ovr", 32'(ovr), 0);
    check("rand_idle_sdo", 32'(sdo), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
